// File: rtl/uart_recv.sv
// 8N1 UART receiver: two-flop synchronizer, start-bit centre sampling,
// LSB-first data capture and stop-bit framing check with one-cycle result pulses.
module uart_recv #(
  parameter int BAUD_CNT_MAX = 10416,
  parameter int HALF_CNT     = BAUD_CNT_MAX / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [14:0] BAUD_LAST = 15'(BAUD_CNT_MAX);
  localparam logic [14:0] HALF_PT   = 15'(HALF_CNT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic        sync1, sync2, din_d;
  logic        fall;
  logic [14:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        half_hit, bit_wrap, stop_hit;

  // Line idles high, so every synchronizer/edge flop resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      din_d <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      din_d <= sync2;
    end
  end

  assign fall     = din_d & ~sync2;
  assign half_hit = (state == START) && (baud_cnt == HALF_PT);
  assign bit_wrap = (state == DATA)  && (baud_cnt == BAUD_LAST);
  assign stop_hit = (state == STOP)  && (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (fall) state_n = START;
      START: if (half_hit) state_n = sync2 ? IDLE : DATA;
      DATA:  if (bit_wrap && bit_cnt == 3'd7) state_n = STOP;
      STOP:  if (stop_hit) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE:  baud_cnt <= '0;
        START: baud_cnt <= half_hit ? 15'd0 : baud_cnt + 15'd1;
        DATA: begin
          baud_cnt <= bit_wrap ? 15'd0 : baud_cnt + 15'd1;
          if (bit_wrap) begin
            shift   <= {sync2, shift[7:1]};
            bit_cnt <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
          end
        end
        STOP:  baud_cnt <= stop_hit ? 15'd0 : baud_cnt + 15'd1;
        default: baud_cnt <= '0;
      endcase
    end
  end

  // A low stop bit leaves data untouched so it always holds the last good byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      data      <= '0;
    end else begin
      valid     <= stop_hit &  sync2;
      frame_err <= stop_hit & ~sync2;
      if (stop_hit && sync2) data <= shift;
    end
  end

endmodule
